// File: rtl/vector_data_memory_pkg.sv
// Shared types and default sizing for the vector data memory responder.
package vector_mem_pkg;

  localparam int REGISTER_SIZE = 8;
  localparam int VECTOR_SIZE   = 4;
  localparam int ADDR_WIDTH    = 8;
  localparam int MEM_DEPTH     = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Default-size lane/vector types; parameterised modules declare the same
  // shape locally as logic [vectorSize-1:0][registerSize-1:0].
  typedef logic [REGISTER_SIZE-1:0]   lane_t;
  typedef lane_t [VECTOR_SIZE-1:0]    vec_t;

  // Counter/index width that never collapses to zero bits.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_data_memory_if.sv
// Request/response handshake bundle between the vector pipeline and the data memory.
interface vector_data_memory_if #(
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int addrWidth    = 8
);
  logic                                   req_valid;
  logic                                   req_ready;
  logic                                   req_we;
  logic [addrWidth-1:0]                   req_addr;
  logic [vectorSize-1:0][registerSize-1:0] req_wdata;
  logic                                   resp_valid;
  logic                                   resp_ready;
  logic [vectorSize-1:0][registerSize-1:0] resp_rdata;
  logic                                   resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/vector_data_memory_array.sv
// Single-port element storage: synchronous write, combinational read. Contents are not reset.
module vector_mem_array #(
  parameter int registerSize = 8,
  parameter int memDepth     = 256,
  parameter int memAw        = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [memAw-1:0]        addr,
  input  logic [registerSize-1:0] wdata,
  output logic [registerSize-1:0] rdata
);
  logic [registerSize-1:0] mem [memDepth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/vector_data_memory.sv
// Vector data-memory responder: one lane per cycle over a single-port array.
// Optional VECTOR_MEM_BOUNDS_CHECK_EN: no address wrap, out-of-range lanes skipped/read 0, resp_err set.
module vector_data_memory
  import vector_mem_pkg::*;
#(
  parameter int registerSize = REGISTER_SIZE,
  parameter int vectorSize   = VECTOR_SIZE,
  parameter int addrWidth    = ADDR_WIDTH,
  parameter int memDepth     = MEM_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_data_memory_if.slave  bus,
  output logic                 busy
);
  localparam int cntW  = idxWidth(vectorSize);
  localparam int memAw = idxWidth(memDepth);
  localparam int sumW  = addrWidth + cntW + 1;

  if (vectorSize > memDepth) begin : gBadVec
    $error("vector_data_memory: vectorSize must not exceed memDepth");
  end
  if (longint'(memDepth) > (longint'(1) << addrWidth)) begin : gBadDepth
    $error("vector_data_memory: memDepth must not exceed 2**addrWidth");
  end

  state_t                                  state, stateNxt;
  logic [cntW-1:0]                         cnt;
  logic                                    capWe;
  logic [addrWidth-1:0]                    capAddr;
  logic [vectorSize-1:0][registerSize-1:0] capWdata;
  logic [vectorSize-1:0][registerSize-1:0] rdataReg;

  logic                    accept, lastLane, laneOob, memWe;
  logic [sumW-1:0]         elemSum;
  logic [memAw-1:0]        elemAddr;
  logic [registerSize-1:0] memRdata, laneRdata;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign lastLane = (cnt == cntW'(vectorSize - 1));
  assign elemSum  = sumW'(capAddr) + sumW'(cnt);
  assign elemAddr = memAw'(elemSum % sumW'(memDepth));

`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
  logic errReg;

  assign laneOob = (elemSum >= sumW'(memDepth));

  // Error is a property of the whole request, so decide it once at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        errReg <= 1'b0;
    else if (accept) errReg <= (sumW'(bus.req_addr) + sumW'(vectorSize - 1)) >= sumW'(memDepth);
  end

  assign bus.resp_err = errReg;
`else
  assign laneOob      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  assign memWe     = (state == ACCESS) && capWe && !laneOob;
  assign laneRdata = laneOob ? '0 : memRdata;

  vector_mem_array #(
    .registerSize (registerSize),
    .memDepth     (memDepth),
    .memAw        (memAw)
  ) uArray (
    .clk   (clk),
    .we    (memWe),
    .addr  (elemAddr),
    .wdata (capWdata[cnt]),
    .rdata (memRdata)
  );

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (accept)         stateNxt = ACCESS;
      ACCESS:  if (lastLane)       stateNxt = RESP;
      RESP:    if (bus.resp_ready) stateNxt = IDLE;
      default:                     stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      capWe    <= 1'b0;
      capAddr  <= '0;
      capWdata <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        cnt      <= '0;
        capWe    <= bus.req_we;
        capAddr  <= bus.req_addr;
        capWdata <= bus.req_wdata;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Each lane register loads only on its own ACCESS cycle of a read.
  for (genvar i = 0; i < vectorSize; i++) begin : gLane
    logic [registerSize-1:0] laneQ;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                                 laneQ <= '0;
      else if (accept)                                          laneQ <= '0;
      else if (state == ACCESS && !capWe && cnt == cntW'(i))    laneQ <= laneRdata;
    end

    assign rdataReg[i] = laneQ;
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdataReg;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_vector_data_memory.sv
// Self-checking bench for vector_data_memory: directed table, multi-cycle corner sequences, random vs. array model.
module tb_vector_data_memory;
  localparam int RS = 8;
  localparam int VS = 4;
  localparam int AW = 8;
  localparam int MD = 256;
`ifdef VECTOR_MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  vector_data_memory_if #(.registerSize(RS), .vectorSize(VS), .addrWidth(AW)) bus ();

  vector_data_memory #(.registerSize(RS), .vectorSize(VS), .addrWidth(AW), .memDepth(MD)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expErr;
  } tvec_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model [MD];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: lane k touches element addr+k, wrapped or (bounds mode) dropped past the end.
  task automatic modelTxn(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
    rd  = '0;
    err = BC && (int'(addr) + VS - 1 >= MD);
    for (int k = 0; k < VS; k++) begin
      int a;
      a = int'(addr) + k;
      if (BC && a >= MD) continue;
      if (we) model[a % MD] = wdata[k*8 +: 8];
      else    rd[k*8 +: 8]  = model[a % MD];
    end
  endtask

  task automatic runTxn(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input int hold, input bit scramble,
                        output logic [31:0] rd, output logic err);
    int          t;
    bit          sawReady;
    logic [31:0] held;
    logic        heldErr;
    rd  = '0;
    err = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 64'(0), 64'(1));
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!scramble) bus.req_valid = 1'b0;
    t = 0;
    sawReady = 1'b0;
    do begin
      @(negedge clk);
      t++;
      if (bus.req_ready) sawReady = 1'b1;
      if (scramble && !bus.resp_valid) begin
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = $urandom;
      end
    end while (!bus.resp_valid && t < 20);
    bus.req_valid = 1'b0;
    check("latency", 64'(t), 64'(VS + 1));
    check("req_ready_low", 64'(sawReady), 64'(0));
    if (!bus.resp_valid) return;
    held    = bus.resp_rdata;
    heldErr = bus.resp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 8'($urandom);
      @(negedge clk);
      check("bp_valid", 64'(bus.resp_valid), 64'(1));
      check("bp_rdata", 64'(bus.resp_rdata), 64'(held));
      check("bp_err",   64'(bus.resp_err),   64'(heldErr));
      check("bp_ready", 64'(bus.req_ready),  64'(0));
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("resp_drop", 64'(bus.resp_valid), 64'(0));
    check("idle_after", 64'({busy, bus.req_ready}), 64'(2'b01));
    rd  = held;
    err = heldErr;
  endtask

  initial begin
    tvec_t       tbl [5];
    logic [31:0] rd, expRd;
    logic        err, expErr;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready",  64'(bus.req_ready),  64'(1));
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_busy",       64'(busy),           64'(0));
    check("rst_rdata",      64'(bus.resp_rdata), 64'(0));
    check("rst_err",        64'(bus.resp_err),   64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.req_ready), 64'(1));

    // Known starting contents.
    for (int a = 0; a < MD; a += VS) begin
      runTxn(1'b1, 8'(a), 32'h0, 0, 1'b0, rd, err);
      modelTxn(1'b1, 8'(a), 32'h0, expRd, expErr);
    end

    tbl[0] = '{1'b1, 8'h10, pack4(8'h11, 8'h22, 8'h33, 8'h44), 32'h0, 1'b0};
    tbl[1] = '{1'b0, 8'h10, 32'h0, pack4(8'h11, 8'h22, 8'h33, 8'h44), 1'b0};
    tbl[2] = '{1'b1, 8'hFE, pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3), 32'h0, BC};
    tbl[3] = '{1'b0, 8'hFE, 32'h0,
               BC ? pack4(8'hA0, 8'hA1, 8'h00, 8'h00) : pack4(8'hA0, 8'hA1, 8'hA2, 8'hA3), BC};
    tbl[4] = '{1'b0, 8'h00, 32'h0,
               BC ? 32'h0 : pack4(8'hA2, 8'hA3, 8'h00, 8'h00), 1'b0};
    for (int i = 0; i < 5; i++) begin
      runTxn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, 1'b0, rd, err);
      modelTxn(tbl[i].we, tbl[i].addr, tbl[i].wdata, expRd, expErr);
      check($sformatf("tbl%0d_rdata", i), 64'(rd),  64'(tbl[i].expRd));
      check($sformatf("tbl%0d_err", i),   64'(err), 64'(tbl[i].expErr));
    end

    // Backpressure: six stalled cycles with a competing request pending.
    runTxn(1'b0, 8'h10, 32'h0, 6, 1'b0, rd, err);
    check("bp_final_rdata", 64'(rd), 64'(pack4(8'h11, 8'h22, 8'h33, 8'h44)));

    // Reset after lane 1 of a write: lanes 0-1 land, 2-3 keep old data, no response.
    runTxn(1'b1, 8'h20, pack4(8'h55, 8'h66, 8'h77, 8'h88), 0, 1'b0, rd, err);
    modelTxn(1'b1, 8'h20, pack4(8'h55, 8'h66, 8'h77, 8'h88), expRd, expErr);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h20;
    bus.req_wdata = pack4(8'h01, 8'h02, 8'h03, 8'h04);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model[8'h20] = 8'h01;
    model[8'h21] = 8'h02;
    #1;
    check("abort_ready", 64'(bus.req_ready),  64'(1));
    check("abort_valid", 64'(bus.resp_valid), 64'(0));
    check("abort_busy",  64'(busy),           64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < VS + 2; c++) begin
      @(negedge clk);
      check("abort_no_resp", 64'(bus.resp_valid), 64'(0));
    end
    runTxn(1'b0, 8'h20, 32'h0, 0, 1'b0, rd, err);
    check("abort_readback", 64'(rd), 64'(pack4(8'h01, 8'h02, 8'h77, 8'h88)));

    // Request inputs change during ACCESS; captured values must win.
    runTxn(1'b1, 8'h40, pack4(8'hDE, 8'hAD, 8'hBE, 8'hEF), 0, 1'b1, rd, err);
    modelTxn(1'b1, 8'h40, pack4(8'hDE, 8'hAD, 8'hBE, 8'hEF), expRd, expErr);
    check("scr_wr_rdata", 64'(rd), 64'(0));
    runTxn(1'b0, 8'h40, 32'h0, 0, 1'b1, rd, err);
    check("scr_rd_rdata", 64'(rd), 64'(pack4(8'hDE, 8'hAD, 8'hBE, 8'hEF)));

    // Random traffic, biased toward the top of memory to hit the wrap/bounds edge.
    for (int n = 0; n < 80; n++) begin
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      we    = 1'($urandom);
      addr  = ($urandom_range(3) == 0) ? 8'(8'hF8 + $urandom_range(7)) : 8'($urandom);
      wdata = $urandom;
      runTxn(we, addr, wdata, int'($urandom_range(2)), 1'b0, rd, err);
      modelTxn(we, addr, wdata, expRd, expErr);
      check("rnd_rdata", 64'(rd),  64'(expRd));
      check("rnd_err",   64'(err), 64'(expErr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
